led_mode_ctrl: RTL and testbench

Controller that sequences the LED display datapath of the board top: generates the rate tick from a free-running counter, synchronises and edge-detects the push-buttons, and runs the display-mode state machine. Its outputs are the four-LED status vector and the gated RGB LED vectors. It sits directly under the top level, between the raw board I/O (`i_sw`, `i_btn`) and the LED pins.

---
 rtl/led_mode_ctrl.sv | 144 ++++++++++++++
 tb/tb_led_mode_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_mode_ctrl.sv
// LED display controller: input synchronisers, rate tick generator, display-mode FSM,
// pattern register and colour gating for the status and RGB LED vectors.
module led_mode_ctrl #(
  parameter int unsigned NB_LEDS    = 4,
  parameter int unsigned NB_COUNTER = 14,
  parameter int unsigned NB_SW      = 4,
  parameter int unsigned R0         = 1023,
  parameter int unsigned R1         = 2047,
  parameter int unsigned R2         = 4095,
  parameter int unsigned R3         = 8191
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [NB_SW-1:0]   i_sw,
  input  logic [NB_SW-1:0]   i_btn,
  output logic [NB_LEDS-1:0] o_led,
  output logic [NB_LEDS-1:0] o_led_r,
  output logic [NB_LEDS-1:0] o_led_g,
  output logic [NB_LEDS-1:0] o_led_b
);

  typedef enum logic [1:0] {SHIFT, FLASH, PINGPONG} mode_e;

  localparam logic [NB_LEDS-1:0] PAT_ONE = NB_LEDS'(1);

  logic [NB_SW-1:0]      sw_s1_q, sw_s2_q;
  logic [NB_SW-1:0]      btn_s1_q, btn_s2_q, btn_prev_q;
  logic [NB_COUNTER-1:0] cnt_q, cnt_d;
  mode_e                 mode_q, mode_d;
  logic [NB_LEDS-1:0]    pat_q, pat_d;
  logic                  dir_q, dir_d;
  logic [2:0]            col_q, col_d;

  logic [NB_SW-1:0]      btn_pulse;
  logic                  run;
  logic                  tick;
  logic [NB_COUNTER-1:0] limit;
  logic [3:0]            status;

  // Button synchronisers keep sampling through reset so prev tracks a held button
  // and no spurious press is seen when reset is released.
  always_ff @(posedge clock) begin
    btn_s1_q   <= i_btn;
    btn_s2_q   <= btn_s1_q;
    btn_prev_q <= btn_s2_q;
    if (i_reset) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      cnt_q   <= '0;
      mode_q  <= SHIFT;
      pat_q   <= PAT_ONE;
      dir_q   <= 1'b1;
      col_q   <= 3'b001;
    end else begin
      sw_s1_q <= i_sw;
      sw_s2_q <= sw_s1_q;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      dir_q   <= dir_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    btn_pulse = btn_s2_q & ~btn_prev_q;
    run       = sw_s2_q[0];
    case (sw_s2_q[2:1])
      2'b00:   limit = NB_COUNTER'(R0);
      2'b01:   limit = NB_COUNTER'(R1);
      2'b10:   limit = NB_COUNTER'(R2);
      default: limit = NB_COUNTER'(R3);
    endcase
    tick = run && (cnt_q >= limit);

    cnt_d  = cnt_q;
    mode_d = mode_q;
    pat_d  = pat_q;
    dir_d  = dir_q;
    col_d  = col_q;

    // A mode change takes precedence over a coincident tick.
    if (btn_pulse[0]) begin
      cnt_d = '0;
      dir_d = 1'b1;
      case (mode_q)
        SHIFT: begin
          mode_d = FLASH;
          pat_d  = '1;
        end
        FLASH: begin
          mode_d = PINGPONG;
          pat_d  = PAT_ONE;
        end
        default: begin
          mode_d = SHIFT;
          pat_d  = PAT_ONE;
        end
      endcase
    end else if (run) begin
      if (tick) begin
        cnt_d = '0;
        case (mode_q)
          SHIFT: begin
            if (sw_s2_q[3]) pat_d = {pat_q[0], pat_q[NB_LEDS-1:1]};
            else            pat_d = {pat_q[NB_LEDS-2:0], pat_q[NB_LEDS-1]};
          end
          FLASH: pat_d = ~pat_q;
          default: begin
            // Reverse at either end so the end positions are shown only once.
            if (dir_q) begin
              if (pat_q[NB_LEDS-1]) begin
                pat_d = pat_q >> 1;
                dir_d = 1'b0;
              end else begin
                pat_d = pat_q << 1;
              end
            end else begin
              if (pat_q[0]) begin
                pat_d = pat_q << 1;
                dir_d = 1'b1;
              end else begin
                pat_d = pat_q >> 1;
              end
            end
          end
        endcase
      end else begin
        cnt_d = cnt_q + NB_COUNTER'(1);
      end
    end

    if      (btn_pulse[1]) col_d = 3'b001;
    else if (btn_pulse[2]) col_d = 3'b010;
    else if (btn_pulse[3]) col_d = 3'b100;

    status  = {run, mode_q == PINGPONG, mode_q == FLASH, mode_q == SHIFT};
    o_led   = NB_LEDS'(status);
    o_led_r = pat_q & {NB_LEDS{col_q[0]}};
    o_led_g = pat_q & {NB_LEDS{col_q[1]}};
    o_led_b = pat_q & {NB_LEDS{col_q[2]}};
  end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Testbench for led_mode_ctrl: directed scenarios plus random stimulus, all compared
// cycle by cycle against a position/phase based reference model.
module tb_led_mode_ctrl;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [3:0] i_sw = 4'b0000;
  logic [3:0] i_btn = 4'b0000;
  logic [3:0] o_led, o_led_r, o_led_g, o_led_b;

  int errors = 0;
  int checks = 0;

  led_mode_ctrl #(
    .NB_LEDS(4), .NB_COUNTER(14), .NB_SW(4),
    .R0(3), .R1(5), .R2(9), .R3(15)
  ) dut (
    .clock  (clk),
    .i_reset(i_reset),
    .i_sw   (i_sw),
    .i_btn  (i_btn),
    .o_led  (o_led),
    .o_led_r(o_led_r),
    .o_led_g(o_led_g),
    .o_led_b(o_led_b)
  );

  always #5 clk = ~clk;

  // Reference model: mode index, shift position, ping-pong phase (0..5), flash state.
  int unsigned m_mode = 0, m_pos = 0, m_pp = 0, m_cnt = 0, m_col = 0;
  bit          m_fon = 1'b1;
  logic [3:0]  h1 = '0, h2 = '0, h3 = '0;
  logic [3:0]  s1 = '0, s2 = '0;

  function automatic int unsigned lim_of(input logic [1:0] sel);
    case (sel)
      2'b00:   return 3;
      2'b01:   return 5;
      2'b10:   return 9;
      default: return 15;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [3:0]  p;
    int unsigned mode, pos, pp, cnt, col;
    bit          fon;
    mode = m_mode; pos = m_pos; pp = m_pp; cnt = m_cnt; col = m_col; fon = m_fon;
    p = h2 & ~h3;
    if (i_reset) begin
      mode = 0; pos = 0; pp = 0; cnt = 0; col = 0; fon = 1'b1;
    end else begin
      if (p[0]) begin
        mode = (mode + 1) % 3; pos = 0; pp = 0; fon = 1'b1; cnt = 0;
      end else if (s2[0]) begin
        if (cnt >= lim_of(s2[2:1])) begin
          cnt = 0;
          case (mode)
            0:       pos = s2[3] ? (pos + 3) % 4 : (pos + 1) % 4;
            1:       fon = !fon;
            default: pp = (pp + 1) % 6;
          endcase
        end else begin
          cnt = cnt + 1;
        end
      end
      if (p[1])      col = 0;
      else if (p[2]) col = 1;
      else if (p[3]) col = 2;
    end
    m_mode <= mode; m_pos <= pos; m_pp <= pp; m_cnt <= cnt; m_col <= col; m_fon <= fon;
    h3 <= h2; h2 <= h1; h1 <= i_btn;
    s2 <= i_reset ? 4'b0000 : s1;
    s1 <= i_reset ? 4'b0000 : i_sw;
  end

  logic [3:0]  e_pat, e_led;
  logic [15:0] exp_v, dut_v;

  always_comb begin
    case (m_mode)
      0:       e_pat = 4'(1 << m_pos);
      1:       e_pat = m_fon ? 4'hF : 4'h0;
      default: e_pat = 4'(1 << ((m_pp <= 3) ? m_pp : 6 - m_pp));
    endcase
    e_led = {s2[0], m_mode == 2, m_mode == 1, m_mode == 0};
    exp_v = {e_led, (m_col == 0) ? e_pat : 4'h0, (m_col == 1) ? e_pat : 4'h0,
             (m_col == 2) ? e_pat : 4'h0};
    dut_v = {o_led, o_led_r, o_led_g, o_led_b};
  end

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== 16'h1100) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: got %h want %h", i, dut_v, 16'h1100);
      end
    end
    i_reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== 16'h1100 || dut_v !== exp_v) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got %h want %h", i, dut_v, 16'h1100);
      end
    end
  endtask

  task automatic test_shift();
    i_sw = 4'b0001;
    for (int i = 0; i < 70; i++) begin
      if (i == 40) i_sw[3] = 1'b1;
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL shift cyc %0d: got %h want %h", i, dut_v, exp_v);
      end
    end
  endtask

  task automatic test_modes();
    i_sw = 4'b0001;
    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < 34; i++) begin
        i_btn[0] = (i < 2);
        @(negedge clk);
        checks++;
        if (dut_v !== exp_v) begin
          errors++;
          $display("FAIL modes m%0d cyc %0d: got %h want %h", m, i, dut_v, exp_v);
        end
      end
    end
  endtask

  task automatic test_colour();
    for (int i = 0; i < 24; i++) begin
      i_btn = (i < 2) ? 4'b1100 : ((i >= 12 && i < 14) ? 4'b1000 : 4'b0000);
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL colour cyc %0d: got %h want %h", i, dut_v, exp_v);
      end
      if (i == 8) begin
        checks++;
        if (o_led_r !== 4'h0 || o_led_b !== 4'h0) begin
          errors++;
          $display("FAIL colour_green_only: got r=%h b=%h want r=0 b=0", o_led_r, o_led_b);
        end
      end
    end
  endtask

  task automatic test_freeze();
    i_sw = 4'b0000;
    for (int i = 0; i < 50; i++) begin
      i_btn = (i >= 20 && i < 22) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL freeze cyc %0d: got %h want %h", i, dut_v, exp_v);
      end
    end
    i_sw = 4'b0111;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL rate_r3 cyc %0d: got %h want %h", i, dut_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    i_sw = 4'b0001;
    for (int i = 0; i < 44; i++) begin
      i_btn = (i < 2 || (i >= 6 && i < 8)) ? 4'b0001 : ((i >= 10 && i < 12) ? 4'b1000 : 4'b0000);
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL pp_setup cyc %0d: got %h want %h", i, dut_v, exp_v);
      end
    end
    i_btn = 4'b0001;
    i_reset = 1'b1;
    repeat (5) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    checks++;
    if (dut_v !== 16'h1100) begin
      errors++;
      $display("FAIL reset_mid_values: got %h want %h", dut_v, 16'h1100);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (o_led[2:0] !== 3'b001 || dut_v !== exp_v) begin
        errors++;
        $display("FAIL held_btn cyc %0d: got %h want %h", i, dut_v, exp_v);
      end
    end
    i_btn = 4'b0000;
    repeat (3) @(negedge clk);
    i_btn = 4'b0001;
    repeat (4) @(negedge clk);
    checks++;
    if (o_led[2:0] !== 3'b010) begin
      errors++;
      $display("FAIL repress_mode: got %b want %b", o_led[2:0], 3'b010);
    end
    i_btn = 4'b0000;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) i_btn = 4'($urandom);
      else if ($urandom_range(0, 1) == 0) i_btn = 4'b0000;
      if ($urandom_range(0, 40) == 0) i_sw = 4'($urandom);
      i_reset = ($urandom_range(0, 150) == 0);
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL random cyc %0d: got %h want %h", i, dut_v, exp_v);
      end
    end
    i_reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_shift();
    test_modes();
    test_colour();
    test_freeze();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
